// File: rtl/resource_arbiter_pkg.sv
// rtl/resource_arbiter_pkg.sv - shared types, error bit positions and one-hot helper for resource_arbiter
package resource_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_t;

    localparam int ERR_TIMEOUT_BIT  = 0;
    localparam int ERR_SPURIOUS_BIT = 1;
    localparam int MAX_REQ          = 32;

    // Callers size-cast the result down to their own lane count.
    function automatic logic [MAX_REQ-1:0] onehot(input int id, input int num_req);
        logic [MAX_REQ-1:0] v;
        v = '0;
        if (id >= 0 && id < num_req && id < MAX_REQ) begin
            v[id] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/resource_arbiter_rr_pick.sv
// rtl/resource_arbiter_rr_pick.sv - combinational rotate-priority picker, first set bit at or above ptr with wrap
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDW-1:0]     i_ptr,
    output logic [IDW-1:0]     o_id,
    output logic               o_any
);

    int w_idx;

    always_comb begin
        o_any = 1'b0;
        o_id  = '0;
        w_idx = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_idx = int'(i_ptr) + off;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!o_any && i_req[w_idx]) begin
                o_any = 1'b1;
                o_id  = IDW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/resource_arbiter.sv
// rtl/resource_arbiter.sv - round-robin arbiter sharing one single-outstanding compute resource between pipelines
module resource_arbiter
    import resource_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 32,
    parameter int RSP_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [DATA_W-1:0]         res_in_data,
    output logic                      res_in_valid,
    input  logic [DATA_W-1:0]         res_out_data,
    input  logic                      res_out_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic                      busy,
    input  logic                      clr_err,
    output logic [1:0]                err_status
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(RSP_TIMEOUT + 1);

    arb_state_t          r_state, w_state_nxt;
    logic [IDW-1:0]      r_id, w_id_nxt;
    logic [IDW-1:0]      r_ptr, w_ptr_nxt;
    logic [IDW-1:0]      w_pick_id, w_id_inc;
    logic                w_pick_any;
    logic [CW-1:0]       r_cnt, w_cnt_nxt;
    logic [NUM_REQ-1:0]  r_grant, w_grant_nxt;
    logic [NUM_REQ-1:0]  r_rsp_valid, w_rsp_valid_nxt;
    logic [NUM_REQ-1:0]  w_id_oh, w_pick_oh;
    logic                r_res_in_valid, w_res_in_valid_nxt;
    logic [DATA_W-1:0]   r_res_in_data, w_res_in_data_nxt;
    logic [DATA_W-1:0]   r_rsp_data, w_rsp_data_nxt;
    logic [1:0]          r_err, w_err_nxt;
    logic                r_busy;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_id  (w_pick_id),
        .o_any (w_pick_any)
    );

    assign w_id_oh   = NUM_REQ'(onehot(int'(r_id), NUM_REQ));
    assign w_pick_oh = NUM_REQ'(onehot(int'(w_pick_id), NUM_REQ));
    // Explicit wrap so non-power-of-two lane counts rotate correctly.
    assign w_id_inc  = (r_id == IDW'(NUM_REQ - 1)) ? '0 : r_id + IDW'(1);

    always_comb begin
        w_state_nxt        = r_state;
        w_id_nxt           = r_id;
        w_ptr_nxt          = r_ptr;
        w_cnt_nxt          = r_cnt;
        w_grant_nxt        = r_grant;
        w_res_in_valid_nxt = 1'b0;
        w_res_in_data_nxt  = r_res_in_data;
        w_rsp_valid_nxt    = '0;
        w_rsp_data_nxt     = r_rsp_data;
        w_err_nxt          = clr_err ? 2'b00 : r_err;

        case (r_state)
            IDLE: begin
                w_grant_nxt = '0;
                if (res_out_valid) begin
                    w_err_nxt[ERR_SPURIOUS_BIT] = 1'b1;
                end
                if (w_pick_any) begin
                    w_id_nxt    = w_pick_id;
                    w_grant_nxt = w_pick_oh;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (res_out_valid) begin
                    w_err_nxt[ERR_SPURIOUS_BIT] = 1'b1;
                end
                if (req_valid[r_id]) begin
                    w_res_in_data_nxt  = req_data[r_id*DATA_W +: DATA_W];
                    w_res_in_valid_nxt = 1'b1;
                    w_grant_nxt        = '0;
                    w_cnt_nxt          = '0;
                    w_state_nxt        = WAIT_RSP;
                end else if (!req[r_id]) begin
                    w_grant_nxt = '0;
                    w_ptr_nxt   = w_id_inc;
                    w_state_nxt = IDLE;
                end
            end
            WAIT_RSP: begin
                if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
                // A response landing on the timeout cycle still completes normally.
                if (res_out_valid) begin
                    w_rsp_data_nxt  = res_out_data;
                    w_rsp_valid_nxt = w_id_oh;
                    w_ptr_nxt       = w_id_inc;
                    w_state_nxt     = IDLE;
                end else if (r_cnt == CW'(RSP_TIMEOUT - 1)) begin
                    w_err_nxt[ERR_TIMEOUT_BIT] = 1'b1;
                    w_ptr_nxt                  = w_id_inc;
                    w_state_nxt                = IDLE;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_id           <= '0;
            r_ptr          <= '0;
            r_cnt          <= '0;
            r_grant        <= '0;
            r_res_in_valid <= 1'b0;
            r_res_in_data  <= '0;
            r_rsp_valid    <= '0;
            r_rsp_data     <= '0;
            r_err          <= 2'b00;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_id           <= w_id_nxt;
            r_ptr          <= w_ptr_nxt;
            r_cnt          <= w_cnt_nxt;
            r_grant        <= w_grant_nxt;
            r_res_in_valid <= w_res_in_valid_nxt;
            r_res_in_data  <= w_res_in_data_nxt;
            r_rsp_valid    <= w_rsp_valid_nxt;
            r_rsp_data     <= w_rsp_data_nxt;
            r_err          <= w_err_nxt;
            r_busy         <= (w_state_nxt != IDLE);
        end
    end

    assign grant        = r_grant;
    assign res_in_data  = r_res_in_data;
    assign res_in_valid = r_res_in_valid;
    assign rsp_data     = r_rsp_data;
    assign rsp_valid    = r_rsp_valid;
    assign busy         = r_busy;
    assign err_status   = r_err;

endmodule

// File: tb/tb_resource_arbiter.sv
// tb/tb_resource_arbiter.sv - scoreboard bench for resource_arbiter with directed scenarios
module tb_resource_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam logic [31:0] RSP_XOR = 32'h00A5_5A00;

    localparam int K_GRANT = 0;
    localparam int K_RESIN = 1;
    localparam int K_RSP   = 2;

    typedef struct {
        int          kind;
        logic [3:0]  lane;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    logic              clk;
    logic              reset;
    logic [NR-1:0]     req;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     grant;
    logic [DW-1:0]     res_in_data;
    logic              res_in_valid;
    logic [DW-1:0]     res_out_data;
    logic              res_out_valid;
    logic [DW-1:0]     rsp_data;
    logic [NR-1:0]     rsp_valid;
    logic              busy;
    logic              clr_err;
    logic [1:0]        err_status;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic [NR-1:0] prev_grant = '0;
    ev_t  exp_q[$];

    resource_arbiter #(
        .NUM_REQ     (NR),
        .DATA_W      (DW),
        .RSP_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .grant         (grant),
        .res_in_data   (res_in_data),
        .res_in_valid  (res_in_valid),
        .res_out_data  (res_out_data),
        .res_out_valid (res_out_valid),
        .rsp_data      (rsp_data),
        .rsp_valid     (rsp_valid),
        .busy          (busy),
        .clr_err       (clr_err),
        .err_status    (err_status)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [3:0] lane, input logic [31:0] data, input int c);
        ev_t e;
        e.kind = kind;
        e.lane = lane;
        e.data = data;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input logic [3:0] lane, input logic [31:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event actual_kind=%0d lane=%b data=%0h expected=none (cycle %0d)",
                     kind, lane, data, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_lane", {28'd0, lane}, {28'd0, e.lane});
            chk("event_data", data, e.data);
            if (e.cyc >= 0) chk("event_cycle", cyc, e.cyc);
        end
    endtask

    // Monitor: samples mid-cycle and retires expectations as the DUT produces events.
    always @(negedge clk) begin
        if (reset) begin
            chk("grant_onehot0", {31'd0, ((grant & (grant - 1'b1)) == '0)}, 32'd1);
            chk("single_active", {31'd0, (int'(grant != '0) + int'(res_in_valid) + int'(rsp_valid != '0)) <= 1}, 32'd1);
            if (grant != '0 && prev_grant == '0) pop_cmp(K_GRANT, grant, 32'd0);
            if (res_in_valid) pop_cmp(K_RESIN, 4'd0, res_in_data);
            if (rsp_valid != '0) pop_cmp(K_RSP, rsp_valid, rsp_data);
        end
        prev_grant <= grant;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, {28'd0, grant}, 32'd0);
        chk({tag, "_res_in_valid"}, {31'd0, res_in_valid}, 32'd0);
        chk({tag, "_res_in_data"}, res_in_data, 32'd0);
        chk({tag, "_rsp_valid"}, {28'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_data"}, rsp_data, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_err"}, {30'd0, err_status}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int due;
        int nrsp;
        logic [31:0] dval;
        int lane;

        reset         = 1'b0;
        req           = '0;
        req_valid     = '0;
        req_data      = '0;
        res_out_data  = '0;
        res_out_valid = 1'b0;
        clr_err       = 1'b0;
        tick;
        tick;
        chk_all_zero("reset");
        reset = 1'b1;
        tick;

        // Single lane: lane 1, payload at cycle 3, response at cycle 6.
        t = cyc;
        req = 4'b0010;
        expect_ev(K_GRANT, 4'b0010, 32'd0, t + 1);
        tick;
        chk("single_busy", {31'd0, busy}, 32'd1);
        tick;
        tick;
        req_valid = 4'b0010;
        req_data[1*DW +: DW] = 32'hDEAD_BEEF;
        expect_ev(K_RESIN, 4'd0, 32'hDEAD_BEEF, t + 4);
        tick;
        req_valid = '0;
        req = '0;
        tick;
        tick;
        res_out_valid = 1'b1;
        res_out_data  = 32'h1234_5678;
        expect_ev(K_RSP, 4'b0010, 32'h1234_5678, t + 7);
        tick;
        res_out_valid = 1'b0;
        chk("single_idle_busy", {31'd0, busy}, 32'd0);
        tick;

        // Contention from a fresh pointer: order must be 0,1,2,3,0.
        reset = 1'b0;
        tick;
        reset = 1'b1;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 32'h1000_0000 + i;
        for (int k = 0; k < 5; k++) begin
            lane = k % NR;
            expect_ev(K_GRANT, 4'b0001 << lane, 32'd0, -1);
            expect_ev(K_RESIN, 4'd0, 32'h1000_0000 + lane, -1);
            expect_ev(K_RSP, 4'b0001 << lane, (32'h1000_0000 + lane) ^ RSP_XOR, -1);
        end
        req = 4'b1111;
        req_valid = 4'b1111;
        due = -1;
        nrsp = 0;
        dval = '0;
        for (int n = 0; n < 200 && nrsp < 5; n++) begin
            tick;
            res_out_valid = 1'b0;
            if (res_in_valid) begin
                due  = cyc + 2;
                dval = res_in_data ^ RSP_XOR;
            end
            if (cyc == due) begin
                res_out_valid = 1'b1;
                res_out_data  = dval;
            end
            if (rsp_valid != '0) nrsp++;
        end
        req = '0;
        req_valid = '0;
        res_out_valid = 1'b0;
        chk("contention_responses", nrsp, 32'd5);
        tick;
        tick;

        // Timeout on lane 2, then lane 3 must win over lane 1.
        t = cyc;
        req = 4'b0100;
        expect_ev(K_GRANT, 4'b0100, 32'd0, t + 1);
        tick;
        req_valid = 4'b0100;
        req_data[2*DW +: DW] = 32'hC0FF_EE02;
        expect_ev(K_RESIN, 4'd0, 32'hC0FF_EE02, t + 2);
        tick;
        req_valid = '0;
        req = 4'b1010;
        for (int n = 0; n < TO - 1; n++) tick;
        chk("timeout_pre_err", {30'd0, err_status}, 32'd0);
        chk("timeout_pre_busy", {31'd0, busy}, 32'd1);
        tick;
        chk("timeout_err", {30'd0, err_status}, 32'd1);
        chk("timeout_busy", {31'd0, busy}, 32'd0);
        chk("timeout_no_rsp", {28'd0, rsp_valid}, 32'd0);
        expect_ev(K_GRANT, 4'b1000, 32'd0, t + 19);
        tick;
        req = '0;
        tick;
        chk("abandon3_grant", {28'd0, grant}, 32'd0);

        // Error clear, spurious response, and set-over-clear priority.
        clr_err = 1'b1;
        tick;
        clr_err = 1'b0;
        chk("clr_err", {30'd0, err_status}, 32'd0);
        res_out_valid = 1'b1;
        res_out_data  = 32'hBAD0_0001;
        tick;
        res_out_valid = 1'b0;
        chk("spurious_err", {30'd0, err_status}, 32'd2);
        clr_err = 1'b1;
        res_out_valid = 1'b1;
        tick;
        res_out_valid = 1'b0;
        chk("set_over_clr", {30'd0, err_status}, 32'd2);
        tick;
        clr_err = 1'b0;
        chk("clr_err2", {30'd0, err_status}, 32'd0);

        // Lane 0 abandons, lane 1 follows.
        t = cyc;
        req = 4'b0001;
        expect_ev(K_GRANT, 4'b0001, 32'd0, t + 1);
        tick;
        req = 4'b0010;
        tick;
        chk("abandon0_grant", {28'd0, grant}, 32'd0);
        chk("abandon0_no_resin", {31'd0, res_in_valid}, 32'd0);
        expect_ev(K_GRANT, 4'b0010, 32'd0, t + 3);
        tick;
        req_valid = 4'b0010;
        req_data[1*DW +: DW] = 32'h55AA_55AA;
        expect_ev(K_RESIN, 4'd0, 32'h55AA_55AA, t + 4);
        tick;
        req_valid = '0;
        req = '0;
        tick;
        chk("wait_busy", {31'd0, busy}, 32'd1);

        // Asynchronous reset while waiting for the resource.
        #3;
        reset = 1'b0;
        #1;
        chk_all_zero("midreset");
        tick;
        tick;
        reset = 1'b1;
        t = cyc;
        req = 4'b0011;
        expect_ev(K_GRANT, 4'b0001, 32'd0, t + 1);
        tick;
        req = '0;
        tick;
        tick;
        tick;
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/resource_arbiter.md
Name: resource_arbiter

Overview:
Round-robin arbiter and transaction sequencer that shares one external compute resource between NUM_REQ stall-capable pipelines.
- Grants the resource to one pipeline at a time and forwards its single-beat request to the resource.
- Waits for the resource response and returns it to the granted pipeline.
- A pipeline's final-stage stall is driven by ~grant[i], so an ungranted pipeline holds its data.

Parameters:
NUM_REQ, 4, number of requesting pipelines (>=2)
DATA_W, 32, request/response data width
RSP_TIMEOUT, 16, max cycles in WAIT_RSP before abort (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
req  input  NUM_REQ  per-pipeline resource request (level)
req_valid  input  NUM_REQ  per-pipeline request data valid (pipeline out_valid_to_resource)
req_data  input  NUM_REQ*DATA_W  per-pipeline request data; slice i = bits [i*DATA_W +: DATA_W]
grant  output  NUM_REQ  one-hot grant (pipeline arbiter_grant)
res_in_data  output  DATA_W  data to resource
res_in_valid  output  1  one-cycle strobe to resource
res_out_data  input  DATA_W  resource response data
res_out_valid  input  1  resource response strobe
rsp_data  output  DATA_W  response data broadcast to all pipelines
rsp_valid  output  NUM_REQ  one-hot, one-cycle response strobe
busy  output  1  high in any state other than IDLE
clr_err  input  1  synchronous clear of err_status
err_status  output  2  sticky errors: bit0 = response timeout, bit1 = spurious response

Behaviour:
- All outputs are registered.
- Reset (asserted low, any time, including mid-transaction): state=IDLE, ptr=0, grant=0, res_in_valid=0, res_in_data=0, rsp_valid=0, rsp_data=0, err_status=0, timeout counter=0.
- FSM states: IDLE, GRANT, WAIT_RSP.
- IDLE:
  - If req!=0, pick the winner as the first set bit searching upward from ptr with wrap-around; latch id.
  - Next cycle: grant=onehot(id), state=GRANT.
  - If req==0, stay in IDLE.
- GRANT:
  - grant held stable.
  - If req_valid[id]=1: next cycle res_in_data=req_data[id], res_in_valid=1 for exactly one cycle, grant=0, counter=0, state=WAIT_RSP.
  - Else if req[id]=0 (abandon): next cycle grant=0, ptr=id+1 mod NUM_REQ, state=IDLE.
  - req_valid on non-granted lanes is ignored.
- WAIT_RSP:
  - Counter increments each cycle.
  - If res_out_valid=1: next cycle rsp_data=res_out_data, rsp_valid=onehot(id) for one cycle, ptr=id+1 mod NUM_REQ, state=IDLE.
  - Else if counter==RSP_TIMEOUT-1: err_status[0] is set, ptr advances, state=IDLE, and no rsp_valid is issued.
  - Response wins when it arrives in the same cycle as the timeout.
- res_out_valid in IDLE or GRANT: data dropped, err_status[1] set.
- clr_err=1: err_status clears next cycle. A set event in the same cycle has priority over clr_err.
- Latency:
  - req seen in IDLE at cycle 0 -> grant at cycle 1.
  - req_valid at cycle k in GRANT -> res_in_valid at k+1.
  - res_out_valid at cycle m -> rsp_valid at m+1.
  - Earliest next grant: 2 cycles after the response strobe (IDLE decision, then grant).
- Fairness: ptr only advances past a lane once that lane completes, abandons, or times out. With all lanes requesting continuously, the grant order is 0,1,2,...,NUM_REQ-1,0.
- Invariants:
  - grant is zero or one-hot.
  - At most one of grant, res_in_valid or rsp_valid is nonzero in any cycle.
  - Only one transaction is outstanding at a time.
- Widths: id and ptr are $clog2(NUM_REQ) bits. The counter is $clog2(RSP_TIMEOUT+1) bits and saturates, never wraps. Wrap of ptr at NUM_REQ-1 -> 0 is explicit, not a power-of-two overflow.

Decomposition:
- Package resource_arbiter_pkg holds:
  - state enum {IDLE, GRANT, WAIT_RSP};
  - ERR_TIMEOUT_BIT=0 and ERR_SPURIOUS_BIT=1;
  - function onehot(id, NUM_REQ).
- One sub-module, rr_pick: combinational rotate-priority picker with inputs req and ptr, outputs id and any.
- FSM, counter and registers live in resource_arbiter.

Test Plan:
- Single lane: reset released, req=4'b0010, req_valid[1]=1 at cycle 3 with data 0xDEADBEEF -> grant=4'b0010 at cycle 1; res_in_valid=1 and res_in_data=0xDEADBEEF at cycle 4; res_out_valid with 0x12345678 at cycle 6 -> rsp_valid=4'b0010 and rsp_data=0x12345678 at cycle 7.
- Contention: req=4'b1111 continuously, resource answers 2 cycles after each request -> grant sequence 0,1,2,3,0; no lane granted twice before all others.
- Timeout: lane 2 sends its request, no response for RSP_TIMEOUT cycles -> err_status=2'b01, busy=0, rsp_valid stays 0, next grant goes to lane 3.
- Spurious/clear: res_out_valid pulsed in IDLE -> err_status=2'b10; clr_err=1 -> err_status=0 next cycle.
- Abandon: lane 0 granted, drops req without req_valid -> grant=0 next cycle, no res_in_valid, lane 1 granted afterwards.
- Reset mid-operation: reset driven low during WAIT_RSP -> all outputs 0 immediately; after release, a new request is granted starting from lane 0.
